// File: rtl/irda_pkg.sv
// Shared types and constants for the IrDA SIR transmitter and its bit timer.
package irda_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } irda_tx_state_e;

  localparam int IRDA_MIN_DIV     = 15;
  localparam int IRDA_PULSE_NUM   = 3;
  localparam int IRDA_PULSE_SHIFT = 4;

  // Even parity over a word zero-extended to 16 bits.
  function automatic logic even_parity(input logic [15:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/irda_bit_timer.sv
// Bit-period phase counter with registered end-of-bit strobe and pulse-window flag.
// div_q/pulse_len must carry the values in force for the next cycle.
import irda_pkg::*;

module irda_bit_timer #(
  parameter int DIV_W = 13
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic [DIV_W-1:0] div_q,
  input  logic [DIV_W-1:0] pulse_len,
  output logic             bit_done,
  output logic             in_pulse
);

  logic [DIV_W-1:0] phase;
  logic [DIV_W-1:0] phase_nxt;

  // Next phase: restart on clear or after the last cycle of a bit.
  always_comb begin
    if (clear || bit_done) begin
      phase_nxt = '0;
    end else begin
      phase_nxt = phase + DIV_W'(1);
    end
  end

  // Flags are computed from the next phase so they line up with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase    <= '0;
      bit_done <= 1'b0;
      in_pulse <= 1'b0;
    end else begin
      phase    <= phase_nxt;
      bit_done <= (phase_nxt == div_q);
      in_pulse <= (phase_nxt < pulse_len);
    end
  end

endmodule

// File: rtl/irda_sir_tx.sv
// IrDA SIR transmitter: async framing with 3/16-period pulses on every 0 bit.
// Define IRDA_PARITY_EN to insert an even-parity bit between data and stop bits.
import irda_pkg::*;

module irda_sir_tx #(
  parameter int DATA_W    = 8,
  parameter int DIV_W     = 13,
  parameter int STOP_BITS = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              ir_tx,
  output logic              bit_done,
  output logic              frame_done,
  output logic              busy
);

  localparam int CNT_W = 4;

  irda_tx_state_e    state;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  pulse_len;
  logic              zero;
`ifdef IRDA_PARITY_EN
  logic              parity;
`endif

  logic [DIV_W-1:0]  div_clamped;
  logic [DIV_W+1:0]  pulse_wide;
  logic [DIV_W-1:0]  pulse_calc;
  logic [DIV_W-1:0]  timer_div;
  logic [DIV_W-1:0]  timer_pulse;
  logic              timer_clear;
  logic              timer_bit_done;
  logic              in_pulse;
  logic              last_stop;

  // Clamp the divisor and derive the pulse length from the candidate word's divisor.
  always_comb begin
    if (baud_div < DIV_W'(IRDA_MIN_DIV)) begin
      div_clamped = DIV_W'(IRDA_MIN_DIV);
    end else begin
      div_clamped = baud_div;
    end
    pulse_wide = ({2'b00, div_clamped} + (DIV_W+2)'(1)) * (DIV_W+2)'(IRDA_PULSE_NUM);
    pulse_calc = DIV_W'(pulse_wide >> IRDA_PULSE_SHIFT);
  end

  // In IDLE the timer must already see the values a transfer would latch.
  always_comb begin
    if (state == IDLE) begin
      timer_div   = div_clamped;
      timer_pulse = pulse_calc;
    end else begin
      timer_div   = div_q;
      timer_pulse = pulse_len;
    end
    timer_clear = (state == IDLE) || !enable;
    last_stop   = (state == STOP) && (bit_cnt == CNT_W'(STOP_BITS - 1));
  end

  irda_bit_timer #(
    .DIV_W (DIV_W)
  ) u_bit_timer (
    .clock     (clock),
    .reset     (reset),
    .clear     (timer_clear),
    .div_q     (timer_div),
    .pulse_len (timer_pulse),
    .bit_done  (timer_bit_done),
    .in_pulse  (in_pulse)
  );

  assign bit_done   = timer_bit_done;
  assign frame_done = timer_bit_done && last_stop;
  assign ir_tx      = zero && in_pulse;
  assign busy       = (state != IDLE);
  assign tx_ready   = (state == IDLE) && enable && !reset;

  // Frame sequencing; zero holds "current bit is 0" for the bit now on the line.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      div_q     <= '0;
      pulse_len <= '0;
      zero      <= 1'b0;
`ifdef IRDA_PARITY_EN
      parity    <= 1'b0;
`endif
    end else if (!enable) begin
      state   <= IDLE;
      bit_cnt <= '0;
      zero    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tx_valid) begin
            state     <= START;
            shreg     <= tx_data;
            div_q     <= div_clamped;
            pulse_len <= pulse_calc;
            bit_cnt   <= '0;
            zero      <= 1'b1;
`ifdef IRDA_PARITY_EN
            parity    <= even_parity(16'(tx_data));
`endif
          end
        end
        START: begin
          if (timer_bit_done) begin
            state <= DATA;
            zero  <= ~shreg[0];
          end
        end
        DATA: begin
          if (timer_bit_done) begin
            shreg <= shreg >> 1;
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              bit_cnt <= '0;
`ifdef IRDA_PARITY_EN
              state   <= PARITY;
              zero    <= ~parity;
`else
              state   <= STOP;
              zero    <= 1'b0;
`endif
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              zero    <= ~shreg[1];
            end
          end
        end
`ifdef IRDA_PARITY_EN
        PARITY: begin
          if (timer_bit_done) begin
            state   <= STOP;
            bit_cnt <= '0;
            zero    <= 1'b0;
          end
        end
`endif
        STOP: begin
          if (timer_bit_done) begin
            if (last_stop) begin
              state   <= IDLE;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
            zero <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
          zero    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irda_sir_tx.sv
// Scoreboard bench for irda_sir_tx: per-bit expectations queued at issue, checked at each bit_done.
module tb_irda_sir_tx;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [12:0] baud_div;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        ir_tx;
  logic        bit_done;
  logic        frame_done;
  logic        busy;

`ifdef IRDA_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif

  typedef struct {
    logic zero;
    int   period;
    int   plen;
    logic last;
  } bit_exp_t;

  bit_exp_t expq[$];
  int tests = 0;
  int fails = 0;

  irda_sir_tx dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .baud_div   (baud_div),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ir_tx      (ir_tx),
    .bit_done   (bit_done),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Frame bits in line order (bit 0 = start); parity of each test word is even except 0x07.
  task automatic push_frame(input logic [7:0] w, input int period, input int plen,
                            input int nexp, input logic full);
    logic [15:0] b;
    bit_exp_t    e;
`ifdef IRDA_PARITY_EN
    b = {5'b0, 1'b1, ^w, w, 1'b0};
`else
    b = {6'b0, 1'b1, w, 1'b0};
`endif
    for (int i = 0; i < nexp; i++) begin
      e.zero   = ~b[i];
      e.period = period;
      e.plen   = e.zero ? plen : 0;
      e.last   = full && (i == nexp - 1);
      expq.push_back(e);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of cycle 0 of the frame.
  task automatic issue(input logic [7:0] w, input logic [12:0] div);
    int n;
    n        = 0;
    tx_data  = w;
    baud_div = div;
    tx_valid = 1'b1;
    while (!tx_ready && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check("tx_ready_before_issue", int'(tx_ready), 1);
    @(negedge clock);
    tx_valid = 1'b0;
    check("busy_after_transfer", int'(busy), 1);
  endtask

  task automatic wait_frame(input int exp_cyc);
    int n;
    n = 0;
    while (!frame_done && n < 5000) begin
      @(negedge clock);
      n++;
    end
    check("frame_done_cycle", n, exp_cyc);
  endtask

  // Monitor: measure each bit period and its pulse, compare against the queue.
  initial begin
    int       cyc;
    int       hi;
    logic     first;
    bit_exp_t e;
    cyc   = 0;
    hi    = 0;
    first = 1'b0;
    forever begin
      @(negedge clock);
      if (reset || !busy) begin
        cyc = 0;
        hi  = 0;
      end else begin
        if (cyc == 0) first = ir_tx;
        cyc++;
        if (ir_tx) hi++;
        if (bit_done) begin
          check("queue_has_entry", (expq.size() > 0) ? 1 : 0, 1);
          if (expq.size() > 0) begin
            e = expq.pop_front();
            check("bit_period", cyc, e.period);
            check("pulse_cycles", hi, e.plen);
            if (e.zero) check("pulse_at_phase0", int'(first), 1);
            check("frame_done_flag", int'(frame_done), int'(e.last));
          end
          cyc = 0;
          hi  = 0;
        end
      end
      if (frame_done) check("frame_done_with_bit_done", int'(bit_done), 1);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int strobes;
    reset    = 1'b1;
    enable   = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    baud_div = 13'd15;
    repeat (3) @(negedge clock);
    check("reset_tx_ready", int'(tx_ready), 0);
    check("reset_ir_tx", int'(ir_tx), 0);
    check("reset_bit_done", int'(bit_done), 0);
    check("reset_frame_done", int'(frame_done), 0);
    check("reset_busy", int'(busy), 0);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", int'(tx_ready), 1);

    // Basic frame, 16-cycle bits, 3-cycle pulses.
    push_frame(8'h55, 16, 3, FBITS, 1'b1);
    issue(8'h55, 13'd15);
    wait_frame(FBITS * 16 - 1);
    @(negedge clock);

    // Divisor below minimum clamps to 16-cycle bits.
    push_frame(8'h00, 16, 3, FBITS, 1'b1);
    issue(8'h00, 13'd4);
    wait_frame(FBITS * 16 - 1);
    @(negedge clock);

    // Back-to-back with tx_valid held; 32-cycle bits give 6-cycle pulses.
    push_frame(8'hA3, 32, 6, FBITS, 1'b1);
    push_frame(8'h3C, 32, 6, FBITS, 1'b1);
    check("b2b_ready_first", int'(tx_ready), 1);
    tx_data  = 8'hA3;
    baud_div = 13'd31;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_data = 8'h3C;
    wait_frame(FBITS * 32 - 1);
    @(negedge clock);
    check("b2b_gap_idle", int'(busy), 0);
    check("b2b_gap_ready", int'(tx_ready), 1);
    @(negedge clock);
    check("b2b_second_started", int'(busy), 1);
    tx_valid = 1'b0;
    wait_frame(FBITS * 32 - 1);
    @(negedge clock);

    // Abort during cycle 50 (bit 3); only bits 0..2 complete.
    push_frame(8'h96, 16, 3, 3, 1'b0);
    issue(8'h96, 13'd15);
    repeat (50) @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    check("abort_idle", int'(busy), 0);
    check("abort_ir_tx", int'(ir_tx), 0);
    check("abort_ready_low", int'(tx_ready), 0);
    strobes = 0;
    repeat (30) begin
      @(negedge clock);
      if (bit_done || frame_done) strobes++;
    end
    check("abort_no_strobes", strobes, 0);
    check("abort_queue_empty", expq.size(), 0);
    enable = 1'b1;
    @(negedge clock);
    push_frame(8'h5A, 16, 3, FBITS, 1'b1);
    issue(8'h5A, 13'd15);
    wait_frame(FBITS * 16 - 1);
    @(negedge clock);

    // 0x07 has odd weight: parity bit is 1, so no pulse in it.
    push_frame(8'h07, 16, 3, FBITS, 1'b1);
    issue(8'h07, 13'd15);
    wait_frame(FBITS * 16 - 1);
    @(negedge clock);

    // Mid-frame divisor change only affects the following frame.
    push_frame(8'h0F, 16, 3, FBITS, 1'b1);
    issue(8'h0F, 13'd15);
    repeat (40) @(negedge clock);
    baud_div = 13'd63;
    wait_frame(FBITS * 16 - 1 - 40);
    @(negedge clock);
    push_frame(8'hF0, 64, 12, FBITS, 1'b1);
    issue(8'hF0, 13'd63);
    wait_frame(FBITS * 64 - 1);

    repeat (3) @(negedge clock);
    check("queue_drained", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
